// File: rtl/ofifo_pkg.sv
// Shared constants and width helpers for the multi-column output FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package ofifo_pkg;

    localparam int DEF_COL   = 8;
    localparam int DEF_BW    = 16;
    localparam int DEF_DEPTH = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Counts must reach DEPTH itself, hence one bit more than the pointers.
    function automatic int cw_of(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_multi_if.sv
// Bus bundle between the PE-column producer / row consumer and the column FIFO.
// Latency: n/a (wires only).
// Backpressure: o_ready/o_afull toward the producer, o_row_avail toward the consumer.
interface ofifo_multi_if #(
    parameter int COL   = ofifo_pkg::DEF_COL,
    parameter int BW    = ofifo_pkg::DEF_BW,
    parameter int DEPTH = ofifo_pkg::DEF_DEPTH
);
    localparam int CW = ofifo_pkg::cw_of(DEPTH);

    logic [COL-1:0]    wr;
    logic [COL*BW-1:0] in;
    logic              rd;
    logic              flush;
    logic [COL*BW-1:0] out;
    logic              o_valid;
    logic              o_row_avail;
    logic              o_full;
    logic              o_afull;
    logic              o_ready;
    logic [CW-1:0]     o_count;
    logic              o_ovf;
    logic              o_udf;

    modport master (
        output wr, in, rd, flush,
        input  out, o_valid, o_row_avail, o_full, o_afull, o_ready, o_count, o_ovf, o_udf
    );

    modport slave (
        input  wr, in, rd, flush,
        output out, o_valid, o_row_avail, o_full, o_afull, o_ready, o_count, o_ovf, o_udf
    );

endinterface

// File: rtl/ofifo_col.sv
// One column queue: DEPTH x BW storage with wrapping pointers and an occupancy count.
// Latency: a push is visible in count/empty the next cycle; head_dat is the current front entry.
// Backpressure: pushes into a full column are dropped and flagged on ovf.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int BW    = DEF_BW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [BW-1:0]            push_dat,
    input  logic                     pop,
    output logic [BW-1:0]            head_dat,
    output logic [cw_of(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = cw_of(DEPTH);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;
    assign ovf      = push && full && !flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofifo_multi.sv
// COL independent column queues; one read pops an aligned row into a registered output.
// Latency: row appears on out one cycle after rd, with a single-cycle o_valid pulse.
// Backpressure: o_ready drops at almost-full; dropped writes set sticky o_ovf, empty reads set o_udf.
module ofifo_multi
    import ofifo_pkg::*;
#(
    parameter int COL      = DEF_COL,
    parameter int BW       = DEF_BW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AFULL_TH = DEPTH - 4
) (
    input logic           clk,
    input logic           reset,
    ofifo_multi_if.slave  bus
);
    localparam int CW = cw_of(DEPTH);

    logic [COL-1:0]    col_full;
    logic [COL-1:0]    col_empty;
    logic [COL-1:0]    col_ovf;
    logic [COL-1:0]    col_afull;
    logic [CW-1:0]     col_cnt  [COL];
    logic [BW-1:0]     col_head [COL];
    logic [CW-1:0]     min_cnt;
    logic              row_avail;
    logic              pop;
    logic              udf_evt;
    logic [COL*BW-1:0] out_q;
    logic              valid_q;
    logic              ovf_q;
    logic              udf_q;

    assign row_avail = ~|col_empty;
    // Flush overrides both the pop and the underflow check for its cycle.
    assign pop       = bus.rd && row_avail && !bus.flush;
    assign udf_evt   = bus.rd && !row_avail && !bus.flush;

    for (genvar g = 0; g < COL; g++) begin : g_col
        ofifo_col #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_col (
            .clk      (clk),
            .reset    (reset),
            .flush    (bus.flush),
            .push     (bus.wr[g]),
            .push_dat (bus.in[BW*g +: BW]),
            .pop      (pop),
            .head_dat (col_head[g]),
            .count    (col_cnt[g]),
            .full     (col_full[g]),
            .empty    (col_empty[g]),
            .ovf      (col_ovf[g])
        );
        assign col_afull[g] = (col_cnt[g] >= CW'(AFULL_TH));
    end

    always_comb begin
        min_cnt = col_cnt[0];
        for (int c = 1; c < COL; c++) begin
            if (col_cnt[c] < min_cnt) min_cnt = col_cnt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                for (int c = 0; c < COL; c++) out_q[BW*c +: BW] <= col_head[c];
            end
            if (|col_ovf) ovf_q <= 1'b1;
            if (udf_evt)  udf_q <= 1'b1;
        end
    end

    assign bus.out         = out_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_row_avail = row_avail;
    assign bus.o_full      = |col_full;
    assign bus.o_afull     = |col_afull;
    assign bus.o_ready     = ~|col_afull;
    assign bus.o_count     = min_cnt;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_udf       = udf_q;

endmodule

// File: tb/tb_ofifo_multi.sv
// Randomized bench for ofifo_multi: per-column queue reference model plus a row scoreboard.
// Latency: expects popped rows on out one cycle after rd.
// Backpressure: models drop-on-full, udf on empty reads, flush and reset.
module tb_ofifo_multi;
    localparam int COL      = 8;
    localparam int BW       = 16;
    localparam int DEPTH    = 64;
    localparam int AFULL_TH = DEPTH - 4;
    localparam int W        = COL * BW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ofifo_multi_if #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) bus ();

    ofifo_multi #(
        .COL      (COL),
        .BW       (BW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: one queue per column, expected popped rows, sticky flags, last row.
    logic [BW-1:0] mq [COL][$];
    logic [W-1:0]  expq [$];
    logic          m_ovf, m_udf, m_valid;
    logic [W-1:0]  m_out;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("row_unexpected", 1, 0);
            end else begin
                logic [W-1:0] row;
                row = expq.pop_front();
                chk("row_data", bus.out, row);
            end
        end
    end

    task automatic step(input logic [COL-1:0] wr, input logic [W-1:0] din,
                        input logic rd, input logic fl, input logic rst);
        int  sz [COL];
        bit  avail;
        bit  pop;
        logic [W-1:0] row;
        int  mn;
        bit  anyfull, anyaf;

        reset     = rst;
        bus.wr    = wr;
        bus.in    = din;
        bus.rd    = rd;
        bus.flush = fl;

        if (rst) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_ovf = 0; m_udf = 0; m_valid = 0; m_out = '0;
        end else begin
            avail = 1;
            for (int c = 0; c < COL; c++) begin
                sz[c] = mq[c].size();
                if (sz[c] == 0) avail = 0;
            end
            pop     = rd && avail && !fl;
            m_valid = pop;
            if (fl) begin
                for (int c = 0; c < COL; c++) mq[c].delete();
            end else begin
                if (rd && !avail) m_udf = 1;
                row = '0;
                for (int c = 0; c < COL; c++) begin
                    if (wr[c]) begin
                        if (sz[c] < DEPTH) mq[c].push_back(din[BW*c +: BW]);
                        else m_ovf = 1;
                    end
                    if (pop) row[BW*c +: BW] = mq[c].pop_front();
                end
                if (pop) begin
                    m_out = row;
                    expq.push_back(row);
                end
            end
        end

        @(posedge clk);
        #1;
        mn = DEPTH; anyfull = 0; anyaf = 0; avail = 1;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() < mn) mn = mq[c].size();
            if (mq[c].size() == DEPTH) anyfull = 1;
            if (mq[c].size() >= AFULL_TH) anyaf = 1;
            if (mq[c].size() == 0) avail = 0;
        end
        chk("o_count",     W'(bus.o_count),     W'(mn));
        chk("o_row_avail", W'(bus.o_row_avail), W'(avail));
        chk("o_full",      W'(bus.o_full),      W'(anyfull));
        chk("o_afull",     W'(bus.o_afull),     W'(anyaf));
        chk("o_ready",     W'(bus.o_ready),     W'(!anyaf));
        chk("o_ovf",       W'(bus.o_ovf),       W'(m_ovf));
        chk("o_udf",       W'(bus.o_udf),       W'(m_udf));
        chk("o_valid",     W'(bus.o_valid),     W'(m_valid));
        chk("out",         bus.out,             m_out);
    endtask

    function automatic logic [W-1:0] rnd_row();
        logic [W-1:0] d;
        for (int c = 0; c < COL; c++) d[BW*c +: BW] = BW'($urandom);
        return d;
    endfunction

    function automatic logic [W-1:0] idx_row(input int k);
        logic [W-1:0] d;
        for (int c = 0; c < COL; c++) d[BW*c +: BW] = BW'(16 * k + c);
        return d;
    endfunction

    initial begin
        reset = 1'b1; bus.wr = '0; bus.in = '0; bus.rd = 1'b0; bus.flush = 1'b0;
        m_ovf = 0; m_udf = 0; m_valid = 0; m_out = '0;

        step('0, '0, 0, 0, 1);
        step('0, '0, 0, 0, 1);

        // In-order row pops after three full-width writes.
        for (int k = 0; k < 3; k++) step('1, idx_row(k), 0, 0, 0);
        for (int k = 0; k < 3; k++) step('0, '0, 1, 0, 0);
        step('0, '0, 0, 0, 0);

        // Skewed column write leaves no complete row; read underflows.
        step(8'h01, rnd_row(), 0, 0, 0);
        step('0, '0, 1, 0, 0);
        step('0, '0, 0, 0, 1);

        // Fill column 3 alone past capacity, then the rest, then drain.
        for (int k = 0; k < DEPTH + 1; k++) step(8'h08, rnd_row(), 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) step(8'hF7, rnd_row(), 0, 0, 0);
        for (int k = 0; k < DEPTH + 1; k++) step('0, '0, 1, 0, 0);
        step('0, '0, 0, 0, 1);

        // Steady state with five rows stored and concurrent push/pop.
        for (int k = 0; k < 5; k++) step('1, rnd_row(), 0, 0, 0);
        for (int k = 0; k < 200; k++) step('1, rnd_row(), 1, 0, 0);

        // Unconstrained random traffic with occasional flush.
        for (int k = 0; k < 400; k++)
            step(COL'($urandom), rnd_row(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 40) == 0), 0);

        // Flush with rows stored and rd asserted: contents gone, out and flags kept.
        step('0, '0, 0, 0, 1);
        step('0, '0, 1, 0, 0);
        for (int k = 0; k < 11; k++) step('1, rnd_row(), 0, 0, 0);
        step('0, '0, 1, 0, 0);
        step('1, rnd_row(), 1, 1, 0);
        step('0, '0, 1, 0, 0);

        // Reset in the middle of traffic.
        for (int k = 0; k < 4; k++) step('1, rnd_row(), k[0], 0, 0);
        step('1, rnd_row(), 1, 0, 1);
        step('0, '0, 0, 0, 0);

        @(negedge clk);
        chk("pending_rows", W'(expq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
